// File: rtl/exp_sub_arbiter_pkg.sv
// Shared constants and types for the exponent-difference subtractor arbiter.
// Holds the default configuration, id-width derivation and response-entry layout.
package exp_sub_arbiter_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_BW      = 5;
    localparam int FIFO_DEPTH  = 2;

    // A single requester still needs a 1-bit id field.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_ID_W = id_width(DEF_NUM_REQ);

    typedef struct packed {
        logic [DEF_ID_W-1:0] id;
        logic                c;
        logic [DEF_BW-1:0]   s;
    } resp_entry_t;

    localparam int DEF_ENTRY_W = $bits(resp_entry_t);

endpackage

// File: rtl/exp_sub_arbiter_rr.sv
// Round-robin grant selection with a last-granted pointer.
// The pointer only moves when a grant is actually accepted.
module exp_sub_arbiter_rr #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               accept,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);

    logic [ID_W-1:0] last;
    logic [ID_W-1:0] cand;

    // Scan from the farthest offset down so the nearest valid index after last wins.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ID_W'((int'(last) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                grant_idx = cand;
                grant_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last <= ID_W'(NUM_REQ - 1);
        end else if (accept) begin
            last <= grant_idx;
        end
    end

endmodule

// File: rtl/full_subtractor.sv
// Unsigned WIDTH-bit subtractor: s = (a - b) mod 2^WIDTH, c = borrow out (a < b).
module full_subtractor #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             c
);

    assign {c, s} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/exp_sub_arbiter.sv
// Time-shares one full_subtractor among NUM_REQ requesters, returning tagged
// results through a 2-entry in-order response FIFO.
module exp_sub_arbiter
    import exp_sub_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int BW      = DEF_BW,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    io_req_valid,
    output logic [NUM_REQ-1:0]    io_req_ready,
    input  logic [NUM_REQ*BW-1:0] io_req_a,
    input  logic [NUM_REQ*BW-1:0] io_req_b,
    output logic                  io_resp_valid,
    input  logic                  io_resp_ready,
    output logic [BW-1:0]         io_resp_s,
    output logic                  io_resp_c,
    output logic [ID_W-1:0]       io_resp_id
);

    localparam int ENTRY_W = ID_W + 1 + BW;

    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic               can_accept;
    logic               accept;
    logic               pop;
    logic [1:0]         count;
    logic [ENTRY_W-1:0] slot0;
    logic [ENTRY_W-1:0] slot1;
    logic [ENTRY_W-1:0] new_entry;
    logic [BW-1:0]      sel_a;
    logic [BW-1:0]      sel_b;
    logic [BW-1:0]      diff_s;
    logic               diff_c;

    exp_sub_arbiter_rr #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .clock     (clock),
        .reset     (reset),
        .req_valid (io_req_valid),
        .accept    (accept),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign io_resp_valid = (count != 2'd0);
    assign pop           = io_resp_valid && io_resp_ready;
    assign can_accept    = (count < 2'(FIFO_DEPTH)) || ((count == 2'(FIFO_DEPTH)) && pop);
    assign accept        = grant_any && can_accept;

    always_comb begin
        io_req_ready = '0;
        if (grant_any) begin
            io_req_ready[grant_idx] = can_accept;
        end
    end

    assign sel_a = io_req_a[int'(grant_idx)*BW +: BW];
    assign sel_b = io_req_b[int'(grant_idx)*BW +: BW];

    full_subtractor #(
        .WIDTH (BW)
    ) u_sub (
        .a (sel_a),
        .b (sel_b),
        .s (diff_s),
        .c (diff_c)
    );

    assign new_entry = {grant_idx, diff_c, diff_s};

    // slot0 is always the head; popping the last entry leaves slot0 untouched so
    // the outputs keep their final values while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case ({accept, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        slot0 <= new_entry;
                    end else begin
                        slot1 <= new_entry;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        slot0 <= slot1;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= new_entry;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= new_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign {io_resp_id, io_resp_c, io_resp_s} = slot0;

endmodule

// File: tb/tb_exp_sub_arbiter.sv
// Scoreboard bench for exp_sub_arbiter: a reference model predicts ready bits and
// pushes expected results; an independent monitor pops and compares responses.
module tb_exp_sub_arbiter;

    localparam int N   = 4;
    localparam int BW  = 5;
    localparam int IDW = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*BW-1:0] req_a = '0;
    logic [N*BW-1:0] req_b = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [BW-1:0]   resp_s;
    logic            resp_c;
    logic [IDW-1:0]  resp_id;

    always #5 clock = ~clock;

    exp_sub_arbiter #(
        .NUM_REQ (N),
        .BW      (BW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_req_valid  (req_valid),
        .io_req_ready  (req_ready),
        .io_req_a      (req_a),
        .io_req_b      (req_b),
        .io_resp_valid (resp_valid),
        .io_resp_ready (resp_ready),
        .io_resp_s     (resp_s),
        .io_resp_c     (resp_c),
        .io_resp_id    (resp_id)
    );

    typedef struct {
        int id;
        int s;
        int c;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;
    int   m_last = N - 1;
    int   m_count = 0;
    bit   rearm = 1'b0;
    int   vprob = 100;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    endtask

    // Round-robin rule: first valid index after the last grant, wrapping around.
    function automatic int model_grant(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input int a, input int b);
        req_a[i*BW +: BW] = BW'(a);
        req_b[i*BW +: BW] = BW'(b);
        req_valid[i]      = 1'b1;
    endtask

    task automatic cycle();
        int           g;
        int           a;
        int           b;
        bit           can;
        bit           popm;
        bit           push;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] acc_mask;
        acc_mask = '0;
        @(negedge clock);
        if (reset) begin
            exp_q.delete();
            m_count = 0;
            m_last  = N - 1;
        end else begin
            chk("resp_valid", int'(resp_valid), int'(m_count > 0));
            g       = model_grant(req_valid, m_last);
            popm    = (m_count > 0) && resp_ready;
            can     = (m_count < 2) || (m_count == 2 && popm);
            push    = (g >= 0) && can;
            exp_rdy = push ? (N'(1) << g) : '0;
            chk("req_ready", int'(req_ready), int'(exp_rdy));
            if (push) begin
                a = int'(req_a[g*BW +: BW]);
                b = int'(req_b[g*BW +: BW]);
                exp_q.push_back('{g, (a - b) & 31, int'(a < b)});
                acc_mask[g] = 1'b1;
                m_last = g;
            end
            m_count = m_count + int'(push) - int'(popm);
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_mask[i] || !req_valid[i]) begin
                if (rearm && $urandom_range(99) < vprob)
                    set_req(i, $urandom_range(31), $urandom_range(31));
                else
                    req_valid[i] = 1'b0;
            end
        end
    endtask

    // Monitor: pops expected results on each handshake, checks head stability
    // under back-pressure and value hold while empty.
    initial begin : monitor
        exp_t e;
        bit   have_prev;
        int   prev_s, prev_c, prev_id;
        int   last_s, last_c, last_id;
        have_prev = 1'b0;
        prev_s = 0; prev_c = 0; prev_id = 0;
        last_s = 0; last_c = 0; last_id = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                have_prev = 1'b0;
                last_s = 0; last_c = 0; last_id = 0;
            end else begin
                if (have_prev) begin
                    chk("hold_s", int'(resp_s), prev_s);
                    chk("hold_c", int'(resp_c), prev_c);
                    chk("hold_id", int'(resp_id), prev_id);
                end
                if (!resp_valid) begin
                    chk("empty_s", int'(resp_s), last_s);
                    chk("empty_c", int'(resp_c), last_c);
                    chk("empty_id", int'(resp_id), last_id);
                end else begin
                    last_s = int'(resp_s); last_c = int'(resp_c); last_id = int'(resp_id);
                end
                if (resp_valid && resp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("resp_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_s", int'(resp_s), e.s);
                        chk("resp_c", int'(resp_c), e.c);
                        chk("resp_id", int'(resp_id), e.id);
                    end
                end
                have_prev = resp_valid && !resp_ready;
                prev_s = int'(resp_s); prev_c = int'(resp_c); prev_id = int'(resp_id);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset = 1'b1;
        repeat (3) cycle();
        chk("rst_valid", int'(resp_valid), 0);
        chk("rst_s", int'(resp_s), 0);
        chk("rst_c", int'(resp_c), 0);
        chk("rst_id", int'(resp_id), 0);
        reset = 1'b0;

        // single request, one-cycle latency
        resp_ready = 1'b1;
        set_req(0, 9, 3);
        cycle();
        chk("single_valid", int'(resp_valid), 1);
        chk("single_s", int'(resp_s), 6);
        chk("single_c", int'(resp_c), 0);
        chk("single_id", int'(resp_id), 0);
        repeat (2) cycle();

        // borrow and full wrap
        set_req(2, 3, 9);
        cycle();
        chk("borrow_s", int'(resp_s), 26);
        chk("borrow_c", int'(resp_c), 1);
        chk("borrow_id", int'(resp_id), 2);
        set_req(2, 0, 31);
        cycle();
        chk("wrap_s", int'(resp_s), 1);
        chk("wrap_c", int'(resp_c), 1);
        repeat (2) cycle();

        // all requesters continuously valid
        rearm = 1'b1;
        vprob = 100;
        for (int i = 0; i < N; i++) set_req(i, $urandom_range(31), $urandom_range(31));
        repeat (12) cycle();

        // back-pressure: FIFO fills, then drains with push+pop at full
        resp_ready = 1'b0;
        repeat (6) cycle();
        chk("bp_ready_zero", int'(req_ready), 0);
        resp_ready = 1'b1;
        repeat (6) cycle();
        rearm = 1'b0;
        req_valid = '0;
        repeat (4) cycle();

        // pointer holds across idle cycles
        set_req(1, 17, 4);
        cycle();
        repeat (5) cycle();
        set_req(0, 5, 5);
        set_req(3, 30, 1);
        #1;
        chk("ptr_first_req3", int'(req_ready), 8);
        cycle();
        #1;
        chk("ptr_second_req0", int'(req_ready), 1);
        repeat (3) cycle();

        // reset with the FIFO full
        resp_ready = 1'b0;
        rearm = 1'b1;
        repeat (5) cycle();
        rearm = 1'b0;
        req_valid = '0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("mid_rst_valid", int'(resp_valid), 0);
        chk("mid_rst_s", int'(resp_s), 0);
        chk("mid_rst_c", int'(resp_c), 0);
        chk("mid_rst_id", int'(resp_id), 0);
        set_req(0, 12, 7);
        set_req(1, 2, 20);
        #1;
        chk("post_rst_req0_first", int'(req_ready), 1);
        resp_ready = 1'b1;
        repeat (4) cycle();

        // randomized traffic with random back-pressure
        rearm = 1'b1;
        vprob = 40;
        repeat (3000) begin
            resp_ready = ($urandom_range(99) < 60);
            cycle();
        end
        rearm = 1'b0;
        req_valid = '0;
        resp_ready = 1'b1;
        repeat (6) cycle();
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
